// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side handshake bundle shared by the I/D-cache memory arbiter.
// The arbiter holds the master view; caches and the memory model sit on the slave view.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              i_read;
  logic              i_write;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  i_read, i_write, i_addr, i_wdata,
    output i_ready, i_rdata,
    input  d_read, d_write, d_addr, d_wdata,
    output d_ready, d_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output i_read, i_write, i_addr, i_wdata,
    input  i_ready, i_rdata,
    output d_read, d_write, d_addr, d_wdata,
    input  d_ready, d_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory line port between I-cache and D-cache; all outputs registered.
// Strobe follows grant by one edge, ready pulses the edge after mem_ready; the loser waits with its request held.
module cache_mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_mem_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ready_q, i_ready_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic i_act;
  logic d_act;
  logic grant_i;
  logic grant_d;

  assign i_act = bus.i_read | bus.i_write;
  assign d_act = bus.d_read | bus.d_write;

  // On a tie, hand the port to whichever side was not served last.
  assign grant_d = d_act & (~i_act | ~last_d_q);
  assign grant_i = i_act & ~grant_d;

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ready_d   = 1'b0;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_write_d = bus.d_write;
          mem_read_d  = ~bus.d_write;
          last_d_d    = 1'b1;
          state_d     = SERVE_D;
        end else if (grant_i) begin
          mem_addr_d  = bus.i_addr;
          mem_wdata_d = bus.i_wdata;
          mem_write_d = bus.i_write;
          mem_read_d  = ~bus.i_write;
          last_d_d    = 1'b0;
          state_d     = SERVE_I;
        end
      end
      SERVE_I: begin
        if (bus.mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          i_ready_d   = 1'b1;
          i_rdata_d   = bus.mem_rdata;
          state_d     = DONE;
        end
      end
      SERVE_D: begin
        if (bus.mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          d_ready_d   = 1'b1;
          d_rdata_d   = bus.mem_rdata;
          state_d     = DONE;
        end
      end
      // One dead cycle lets the served cache drop its request before rearbitration.
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_ready_q   <= d_ready_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_ready_q && d_ready_q));
  a_strobe_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_read_q && mem_write_q));
  a_ready_single: assert property (@(posedge clk) disable iff (!rst_n)
    (i_ready_q || d_ready_q) |=> !(i_ready_q || d_ready_q));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (bus.mem_read || bus.mem_write) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes got %b expected 0000",
               {bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready});
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_addr_wdata got %h/%h expected 0/0", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata got %h/%h expected 0/0", bus.i_rdata, bus.d_rdata);
    end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_i_read();
    logic [DATA_W-1:0] pat;
    int hi_cnt;
    pat = {16{8'hA5}};
    bus.i_read = 1'b1;
    bus.i_addr = 28'h0000010;
    tick();
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 28'h0000010) begin
      errors++;
      $display("FAIL ird_grant got rd=%b wr=%b addr=%h expected 1 0 0000010",
               bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    hi_cnt = 1;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (bus.mem_read === 1'b1) hi_cnt++;
    end
    checks++;
    if (hi_cnt !== 5) begin
      errors++;
      $display("FAIL ird_strobe_len got %0d expected 5", hi_cnt);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = pat;
    tick();
    bus.mem_ready = 1'b0;
    bus.i_read = 1'b0;
    checks++;
    if (bus.i_ready !== 1'b1 || bus.i_rdata !== pat || bus.d_ready !== 1'b0 || bus.mem_read !== 1'b0) begin
      errors++;
      $display("FAIL ird_ready got i_rdy=%b d_rdy=%b rd=%b rdata=%h expected 1 0 0 %h",
               bus.i_ready, bus.d_ready, bus.mem_read, bus.i_rdata, pat);
    end
    tick();
    checks++;
    if (bus.i_ready !== 1'b0 || bus.i_rdata !== pat) begin
      errors++;
      $display("FAIL ird_pulse_end got i_rdy=%b rdata=%h expected 0 %h", bus.i_ready, bus.i_rdata, pat);
    end
    tick();
    checks++;
    if (bus.mem_read !== 1'b0 || bus.d_ready !== 1'b0) begin
      errors++;
      $display("FAIL ird_idle got rd=%b d_rdy=%b expected 0 0", bus.mem_read, bus.d_ready);
    end
  endtask

  task automatic test_dwb_alloc();
    bus.d_write = 1'b1;
    bus.d_addr  = 28'h0000200;
    bus.d_wdata = 128'h1234;
    tick();
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 28'h0000200 ||
        bus.mem_wdata !== 128'h1234) begin
      errors++;
      $display("FAIL dwb_grant got wr=%b rd=%b addr=%h wdata=%h expected 1 0 0000200 1234",
               bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata);
    end
    bus.d_wdata = 128'hDEAD;
    bus.d_addr  = 28'h0000999;
    tick();
    checks++;
    if (bus.mem_wdata !== 128'h1234 || bus.mem_addr !== 28'h0000200) begin
      errors++;
      $display("FAIL dwb_hold got addr=%h wdata=%h expected 0000200 1234", bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'h77;
    tick();
    bus.mem_ready = 1'b0;
    checks++;
    if (bus.d_ready !== 1'b1 || bus.mem_write !== 1'b0 || bus.i_ready !== 1'b0) begin
      errors++;
      $display("FAIL dwb_ready got d_rdy=%b wr=%b i_rdy=%b expected 1 0 0",
               bus.d_ready, bus.mem_write, bus.i_ready);
    end
    bus.d_write = 1'b0;
    bus.d_read  = 1'b1;
    bus.d_addr  = 28'h0000200;
    tick();
    checks++;
    if (bus.mem_read !== 1'b0 || bus.d_ready !== 1'b0) begin
      errors++;
      $display("FAIL dwb_done_nogrant got rd=%b d_rdy=%b expected 0 0", bus.mem_read, bus.d_ready);
    end
    tick();
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 28'h0000200) begin
      errors++;
      $display("FAIL dalloc_grant got rd=%b wr=%b addr=%h expected 1 0 0000200",
               bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'hCAFE;
    tick();
    bus.mem_ready = 1'b0;
    bus.d_read = 1'b0;
    checks++;
    if (bus.d_ready !== 1'b1 || bus.d_rdata !== 128'hCAFE || bus.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL dalloc_ready got d_rdy=%b rdata=%h wr=%b expected 1 cafe 0",
               bus.d_ready, bus.d_rdata, bus.mem_write);
    end
    tick();
    tick();
  endtask

  task automatic test_tie();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_read = 1'b1;
    bus.i_addr = 28'h00000A1;
    bus.d_read = 1'b1;
    bus.d_addr = 28'h00000D1;
    tick();
    checks++;
    if (bus.mem_addr !== 28'h00000D1 || bus.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL tie_first got addr=%h rd=%b expected 00000d1 1", bus.mem_addr, bus.mem_read);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    bus.d_read = 1'b0;
    checks++;
    if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_d_ready got d=%b i=%b expected 1 0", bus.d_ready, bus.i_ready);
    end
    tick();
    tick();
    checks++;
    if (bus.mem_addr !== 28'h00000A1 || bus.mem_read !== 1'b1 || bus.i_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_second got addr=%h rd=%b i_rdy=%b expected 00000a1 1 0",
               bus.mem_addr, bus.mem_read, bus.i_ready);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    bus.i_read = 1'b0;
    checks++;
    if (bus.i_ready !== 1'b1 || bus.d_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_i_ready got i=%b d=%b expected 1 0", bus.i_ready, bus.d_ready);
    end
    tick();
  endtask

  task automatic test_fairness();
    bit ok;
    bit exp_d;
    bit got_d;
    bus.i_read = 1'b1;
    bus.i_addr = 28'h0000111;
    bus.d_read = 1'b1;
    bus.d_addr = 28'h0000222;
    for (int n = 0; n < 6; n++) begin
      exp_d = (n % 2 == 0);
      wait_strobe(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL fair_timeout txn %0d got no strobe expected strobe", n);
      end
      got_d = (bus.mem_addr == 28'h0000222);
      checks++;
      if (got_d !== exp_d) begin
        errors++;
        $display("FAIL fair_order txn %0d got d=%b expected d=%b", n, got_d, exp_d);
      end
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      checks++;
      if ({bus.d_ready, bus.i_ready} !== (exp_d ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL fair_ready txn %0d got d/i=%b%b expected d=%b",
                 n, bus.d_ready, bus.i_ready, exp_d);
      end
      tick();
    end
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    wait_strobe(ok);
    tick();
  endtask

  task automatic test_mid_reset();
    bus.d_read = 1'b1;
    bus.d_addr = 28'h0000300;
    tick();
    checks++;
    if (bus.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL mrst_serve got rd=%b expected 1", bus.mem_read);
    end
    bus.d_read = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.d_ready, bus.i_ready} !== 4'b0000 ||
        bus.mem_addr !== '0 || bus.d_rdata !== '0) begin
      errors++;
      $display("FAIL mrst_async got strobes=%b addr=%h d_rdata=%h expected 0000 0 0",
               {bus.mem_read, bus.mem_write, bus.d_ready, bus.i_ready}, bus.mem_addr, bus.d_rdata);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'hFFFF;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.d_ready, bus.i_ready} !== 4'b0000 || bus.d_rdata !== '0) begin
      errors++;
      $display("FAIL mrst_idle got strobes=%b d_rdata=%h expected 0000 0",
               {bus.mem_read, bus.mem_write, bus.d_ready, bus.i_ready}, bus.d_rdata);
    end
  endtask

  task automatic test_rw_conflict();
    int rd_seen;
    int pulses;
    rd_seen = 0;
    pulses  = 0;
    bus.d_read  = 1'b1;
    bus.d_write = 1'b1;
    bus.d_addr  = 28'h0000400;
    bus.d_wdata = 128'h55;
    tick();
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_wdata !== 128'h55) begin
      errors++;
      $display("FAIL rw_write_wins got wr=%b rd=%b wdata=%h expected 1 0 55",
               bus.mem_write, bus.mem_read, bus.mem_wdata);
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      if (bus.mem_read === 1'b1) rd_seen++;
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    if (bus.d_ready === 1'b1) pulses++;
    if (bus.mem_read === 1'b1) rd_seen++;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (bus.d_ready === 1'b1) pulses++;
      if (bus.mem_read === 1'b1) rd_seen++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL rw_pulses got %0d expected 1", pulses);
    end
    checks++;
    if (rd_seen !== 0) begin
      errors++;
      $display("FAIL rw_no_read got %0d read cycles expected 0", rd_seen);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.i_read = 1'b0;
    bus.i_write = 1'b0;
    bus.i_addr = '0;
    bus.i_wdata = '0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    test_reset();
    test_single_i_read();
    test_dwb_alloc();
    test_tie();
    test_fairness();
    test_mid_reset();
    test_rw_conflict();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
